linear_layer_start_token_fifo: RTL and testbench
================================================

// Module: linear_layer_start_token_fifo
// PURPOSE
//  Controller for the start-token FIFO between two dataflow stages of the i4xi4 linear layer.
//  Producer side pushes start tokens, consumer side (PE start logic) pops them.
//  Owns push/pop accounting, full/empty flags and the read address. Drives a shift-register store.
//  Show-ahead: the oldest token is visible on if_dout whenever if_empty_n=1.
// PARAMETERS
//  DATA_WIDTH  1  token width in bits
//  ADDR_WIDTH  1  read-address width; DEPTH <= 2**ADDR_WIDTH
//  DEPTH       2  token capacity; legal range 2..2**ADDR_WIDTH
// PORTS
//  clk                input   1             single clock; all state on rising edge
//  rst_n              input   1             synchronous, active-low reset
//  if_write           input   1             producer push request
//  if_din             input   DATA_WIDTH    token to push
//  if_full_n          output  1             1 = space available; push accepted iff if_write & if_full_n
//  if_read            input   1             consumer pop request
//  if_dout            output  DATA_WIDTH    oldest token (combinational from store)
//  if_empty_n         output  1             1 = token available; pop accepted iff if_read & if_empty_n
//  if_num_data_valid  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  if_fifo_cap        output  ADDR_WIDTH+1  constant DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): count=0, if_empty_n=0, if_full_n=1, if_num_data_valid=0.
//    Store contents not reset; if_dout undefined while empty. Reset mid-stream discards all tokens.
//  - push = if_write & if_full_n; pop = if_read & if_empty_n (flags are registered, not comb).
//  - Store write-enable = push; every push shifts the store by one and writes if_din at slot 0.
//  - Read address = count-1 (ADDR_WIDTH bits); at count=0 address is don't-care (drive 0).
//  - count update: push&!pop -> +1; pop&!push -> -1; both or neither -> unchanged.
//  - Simultaneous push+pop (only possible when 0<count<DEPTH): shift moves next-oldest token
//    into slot count-1, so address is unchanged; popped token is the pre-edge if_dout.
//  - Push while full: ignored, count and store unchanged. Pop while empty: ignored.
//  - if_read & if_write while empty: push only; token visible on if_dout next cycle.
//  - if_read & if_write while full: pop only; if_full_n=1 next cycle.
//  - Flags registered from next count: if_empty_n <= (count_nxt!=0); if_full_n <= (count_nxt!=DEPTH).
//  - Latency: push to if_empty_n=1 = 1 cycle; pop to if_full_n=1 = 1 cycle.
//  - Order strictly FIFO; no token lost or duplicated under any request pattern.
//  - if_num_data_valid = count (registered). count never exceeds DEPTH, never below 0.
// STRUCTURE
//  - Shared package linear_layer_pkg: start-token typedef (token_t), FIFO occupancy-width helper
//    function clog2_p1(DEPTH), default start-FIFO DEPTH constant.
//  - One sub-module: linear_layer_start_token_srl (clk, we, addr, din, dout), shift-register
//    store of DEPTH x DATA_WIDTH, no reset, asynchronous read at addr. Controller holds all state.
//  - Elaboration-time check: DEPTH>=2 and DEPTH<=2**ADDR_WIDTH, else $fatal.
// TESTING
//  - Reset: hold rst_n=0 2 cycles with if_write=1 -> if_empty_n=0, if_full_n=1, count=0 throughout.
//  - Fill/drain DEPTH=2: push 1,0 -> if_full_n=0 after 2nd edge; 3rd push ignored; pops return 1,0.
//  - Simultaneous: count=1 holding 1, push 0 + pop same cycle -> popped 1, count=1, if_dout=0.
//  - Boundary: full + if_read&if_write -> pop only, count=DEPTH-1; empty + both -> push only, count=1.
//  - Reset mid-stream: count=2, assert rst_n=0 one cycle -> count=0, if_empty_n=0, pops ignored.
//  - Random push/pop 10k cycles, DEPTH=4, ADDR_WIDTH=2, DATA_WIDTH=8 vs queue model -> zero mismatches.

Source files
------------

// File: rtl/linear_layer_pkg.sv
// linear_layer_pkg: shared types, constants and helpers for the i4xi4 linear layer
package linear_layer_pkg;
  localparam int START_FIFO_DEPTH = 2;
  typedef logic [0:0] token_t;
  function automatic int clog2_p1(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/linear_layer_start_token_srl.sv
// linear_layer_start_token_srl: shift-register token store, new token at slot 0, async read
module linear_layer_start_token_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // every write shifts older tokens one slot deeper; contents are never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end
  assign dout = mem[addr];
endmodule

// File: rtl/linear_layer_start_token_fifo.sv
// linear_layer_start_token_fifo: show-ahead start-token FIFO controller over a shift-register store
module linear_layer_start_token_fifo
  import linear_layer_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH = START_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);
  if (DEPTH < 2 || clog2_p1(DEPTH) > ADDR_WIDTH + 1) begin : g_bad_depth
    $fatal(1, "linear_layer_start_token_fifo: DEPTH must be in 2..2**ADDR_WIDTH");
  end
  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(DEPTH);
  logic [ADDR_WIDTH:0]   count_q, count_d, count_m1;
  logic                  empty_n_q, full_n_q, push, pop;
  logic [ADDR_WIDTH-1:0] addr;
  // accept requests only against registered flags; the oldest token sits at slot count-1
  always_comb begin
    push = if_write & full_n_q;
    pop = if_read & empty_n_q;
    count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    count_m1 = count_q - 1'b1;
    addr = (count_q == '0) ? '0 : count_m1[ADDR_WIDTH-1:0];
  end
  // occupancy and flags, flags precomputed from the next count so they are registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      empty_n_q <= 1'b0;
      full_n_q <= 1'b1;
    end else begin
      count_q <= count_d;
      empty_n_q <= (count_d != '0);
      full_n_q <= (count_d != CAP);
    end
  end
  linear_layer_start_token_srl #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH)
  ) u_srl (
    .clk(clk),
    .we(push),
    .addr(addr),
    .din(if_din),
    .dout(if_dout)
  );
  assign if_full_n = full_n_q;
  assign if_empty_n = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_fifo_cap = CAP;
endmodule

// File: tb/tb_linear_layer_start_token_fifo.sv
// tb_linear_layer_start_token_fifo: directed checks on DEPTH=2 plus queue-model run on DEPTH=4
module tb_linear_layer_start_token_fifo;
  logic clk = 1'b0;
  logic rst_n;
  logic a_write, a_read, a_full_n, a_empty_n;
  logic [0:0] a_din, a_dout;
  logic [1:0] a_num, a_cap;
  logic b_write, b_read, b_full_n, b_empty_n;
  logic [7:0] b_din, b_dout;
  logic [2:0] b_num, b_cap;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  linear_layer_start_token_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .if_write(a_write), .if_din(a_din), .if_full_n(a_full_n),
    .if_read(a_read), .if_dout(a_dout), .if_empty_n(a_empty_n),
    .if_num_data_valid(a_num), .if_fifo_cap(a_cap)
  );
  linear_layer_start_token_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .if_write(b_write), .if_din(b_din), .if_full_n(b_full_n),
    .if_read(b_read), .if_dout(b_dout), .if_empty_n(b_empty_n),
    .if_num_data_valid(b_num), .if_fifo_cap(b_cap)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic a_state(input string tag, input int cnt, input logic e, input logic f);
    chk({tag, "_cnt"}, 32'(a_num), 32'(cnt));
    chk({tag, "_empty_n"}, 32'(a_empty_n), 32'(e));
    chk({tag, "_full_n"}, 32'(a_full_n), 32'(f));
  endtask
  initial begin
    logic [7:0] q[$];
    logic w, r;
    rst_n = 1'b0; a_write = 1'b1; a_din = 1'b1; a_read = 1'b0;
    b_write = 1'b0; b_read = 1'b0; b_din = '0;
    step();
    a_state("rst1", 0, 1'b0, 1'b1);
    step();
    a_state("rst2", 0, 1'b0, 1'b1);
    chk("cap_a", 32'(a_cap), 32'd2);
    chk("cap_b", 32'(b_cap), 32'd4);
    rst_n = 1'b1; a_din = 1'b1;
    step();
    a_state("push1", 1, 1'b1, 1'b1);
    chk("push1_dout", 32'(a_dout), 32'd1);
    a_din = 1'b0;
    step();
    a_state("push2", 2, 1'b1, 1'b0);
    chk("push2_dout", 32'(a_dout), 32'd1);
    a_din = 1'b1;
    step();
    a_state("push_full", 2, 1'b1, 1'b0);
    chk("push_full_dout", 32'(a_dout), 32'd1);
    a_write = 1'b0; a_read = 1'b1;
    step();
    a_state("pop1", 1, 1'b1, 1'b1);
    chk("pop1_dout", 32'(a_dout), 32'd0);
    step();
    a_state("pop2", 0, 1'b0, 1'b1);
    step();
    a_state("pop_empty", 0, 1'b0, 1'b1);
    a_write = 1'b1; a_din = 1'b1; a_read = 1'b0;
    step();
    a_state("sim_pre", 1, 1'b1, 1'b1);
    a_din = 1'b0; a_read = 1'b1;
    chk("sim_popped", 32'(a_dout), 32'd1);
    step();
    a_state("sim_post", 1, 1'b1, 1'b1);
    chk("sim_dout", 32'(a_dout), 32'd0);
    a_din = 1'b1; a_read = 1'b0;
    step();
    a_state("full_pre", 2, 1'b1, 1'b0);
    chk("full_pre_dout", 32'(a_dout), 32'd0);
    a_din = 1'b0; a_read = 1'b1;
    step();
    a_state("full_both", 1, 1'b1, 1'b1);
    chk("full_both_dout", 32'(a_dout), 32'd1);
    a_write = 1'b0;
    step();
    a_state("drain", 0, 1'b0, 1'b1);
    a_write = 1'b1; a_din = 1'b1;
    step();
    a_state("empty_both", 1, 1'b1, 1'b1);
    chk("empty_both_dout", 32'(a_dout), 32'd1);
    a_din = 1'b0; a_read = 1'b0;
    step();
    a_state("mid_pre", 2, 1'b1, 1'b0);
    rst_n = 1'b0; a_write = 1'b0;
    step();
    a_state("mid_rst", 0, 1'b0, 1'b1);
    rst_n = 1'b1; a_read = 1'b1;
    step();
    a_state("mid_pop", 0, 1'b0, 1'b1);
    a_read = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      int hi;
      hi = ((c / 400) % 2 == 0) ? 3 : 1;
      w = ($urandom_range(3) < hi);
      r = ($urandom_range(3) < 4 - hi);
      b_write = w; b_read = r; b_din = 8'($urandom);
      chk("rnd_cnt", 32'(b_num), 32'(q.size()));
      chk("rnd_empty_n", 32'(b_empty_n), 32'(q.size() != 0));
      chk("rnd_full_n", 32'(b_full_n), 32'(q.size() != 4));
      if (q.size() != 0) chk("rnd_dout", 32'(b_dout), 32'(q[0]));
      begin
        logic pu, po;
        pu = w && q.size() < 4;
        po = r && q.size() > 0;
        if (po) void'(q.pop_front());
        if (pu) q.push_back(b_din);
      end
      step();
    end
    b_write = 1'b0; b_read = 1'b0;
    chk("rnd_final_cnt", 32'(b_num), 32'(q.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
